// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch stage's memory request/response, decode and redirect signals.
// Every valid/ready pair transfers on a cycle where both are high at the rising clock edge;
// imem_rsp_valid has no ready (always accepted) and redirect_valid is a one-cycle pulse.
interface fetch_if;

    logic                       imem_req_valid;
    logic                       imem_req_ready;
    logic [fetch_pkg::XLEN-1:0] imem_req_addr;
    logic                       imem_rsp_valid;
    logic [fetch_pkg::XLEN-1:0] imem_rsp_data;
    logic                       instr_valid;
    logic                       instr_ready;
    logic [fetch_pkg::XLEN-1:0] instr_data;
    logic [fetch_pkg::XLEN-1:0] instr_pc;
    logic                       redirect_valid;
    logic [fetch_pkg::XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; a push into a full FIFO is taken
// when a pop happens in the same cycle. Head reads as zero while empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited word requests, in-order responses, PC-tagged
// instruction buffer and redirect flush. Define FETCH_PERF_EN to add performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          BUF_DEPTH       = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_if.master      bus,
    output fetch_state_t dbg_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_dropped,
    output logic [31:0]  perf_stall
`endif
);

    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int BCW = $clog2(BUF_DEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] drop_cnt_q, drop_cnt_d;

    logic [BCW-1:0] buf_count;
    logic [OW-1:0]  tag_count;
    fetch_entry_t   buf_head, buf_entry, tag_head, tag_entry;
    logic [31:0]    credit_used;
    logic           issue_ok, req_fire, rsp_fire, rsp_stale, buf_push, buf_pop;
    logic           unused_tag;

    // Live in-flight words plus buffered words never exceed the buffer size,
    // so every non-stale response is guaranteed a slot.
    assign credit_used = 32'(outstanding_q) - 32'(drop_cnt_q) + 32'(buf_count);
    assign issue_ok    = (state_q != BOOT) && !bus.redirect_valid
                      && (outstanding_q < OW'(MAX_OUTSTANDING))
                      && (credit_used < 32'(BUF_DEPTH));
    assign req_fire    = issue_ok && bus.imem_req_ready;
    assign rsp_fire    = bus.imem_rsp_valid && (outstanding_q != '0);
    assign rsp_stale   = rsp_fire && (bus.redirect_valid || (drop_cnt_q != '0));
    assign buf_push    = rsp_fire && !rsp_stale;
    assign buf_pop     = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;

    assign tag_entry = '{pc: fetch_pc_q, data: NOP_INSTR};
    assign buf_entry = '{pc: tag_head.pc, data: bus.imem_rsp_data};

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + OW'(req_fire) - OW'(rsp_fire);
        if (req_fire) fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
        if (rsp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OW'(1);
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            FLUSH:   if (drop_cnt_d == '0) state_d = RUN;
            default: state_d = BOOT;
        endcase
        // Redirect overrides everything; whatever is still in flight becomes stale.
        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            drop_cnt_d = outstanding_d;
            state_d    = (outstanding_d != '0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_instr_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (bus.redirect_valid),
        .push       (buf_push),
        .push_entry (buf_entry),
        .pop        (buf_pop),
        .head       (buf_head),
        .count      (buf_count)
    );

    // Tags are not flushed on redirect: stale responses still pop their tag.
    fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_pc_tags (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (1'b0),
        .push       (req_fire),
        .push_entry (tag_entry),
        .pop        (rsp_fire),
        .head       (tag_head),
        .count      (tag_count)
    );

    assign unused_tag = ^{tag_head.data, tag_count};

    assign bus.imem_req_valid = issue_ok;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.instr_valid    = (buf_count != '0);
    assign bus.instr_data     = buf_head.data;
    assign bus.instr_pc       = buf_head.pc;
    assign dbg_state          = state_q;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            if (buf_push && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
            if (rsp_stale && (perf_dropped != '1)) perf_dropped <= perf_dropped + 32'd1;
            if ((state_q != BOOT) && bus.instr_ready && !bus.instr_valid && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

    rsp_without_request_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.imem_rsp_valid && (outstanding_q == '0)))
        else $error("imem response arrived with no request outstanding");

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized memory latency,
// backpressure and redirects, checked against a sequential-PC stream model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    fetch_state_t dbg_state;
`ifdef FETCH_PERF_EN
    logic [31:0]  perf_fetched, perf_dropped, perf_stall;
`endif

    fetch_if bus();

    fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .dbg_state    (dbg_state)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int first_valid_cyc = -1;
    int n_req = 0;
    int n_pop = 0;
    int req_ready_pct = 100;
    int instr_ready_pct = 100;
    int lat_min = 0;
    int lat_max = 0;
    int p0;
    int k;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] acc_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_next_pc;
    logic        redirect_pending = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        prev_stalled = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        last_req_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Delivered stream must be consecutive words starting at the last reset/redirect target.
    function automatic void exp_restart(input logic [31:0] pc);
        exp_q.delete();
        exp_next_pc = pc;
    endfunction

    function automatic logic [31:0] exp_pop();
        while (exp_q.size() < 2) begin
            exp_q.push_back(exp_next_pc);
            exp_next_pc += 32'd4;
        end
        return exp_q.pop_front();
    endfunction

    // One clock cycle: drive at posedge+1, observe at negedge, advance.
    task automatic tick();
        logic [31:0] e;
        bus.imem_rsp_valid = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
        bus.imem_rsp_data  = bus.imem_rsp_valid ? (pend_addr[0] ^ KEY) : $urandom;
        bus.imem_req_ready = ($urandom_range(99) < req_ready_pct);
        bus.instr_ready    = ($urandom_range(99) < instr_ready_pct);
        bus.redirect_valid = redirect_pending;
        bus.redirect_pc    = redirect_pending ? redirect_target : $urandom;
        redirect_pending   = 1'b0;
        @(negedge clk);
        if (prev_stalled && !bus.redirect_valid) begin
            check("req_hold_valid", 32'(bus.imem_req_valid), 32'd1);
            check("req_hold_addr", bus.imem_req_addr, prev_addr);
        end
        last_req_valid = bus.imem_req_valid;
        prev_stalled   = bus.imem_req_valid && !bus.imem_req_ready;
        prev_addr      = bus.imem_req_addr;
        if (bus.instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("addr_align", 32'(bus.imem_req_addr[1:0]), 32'd0);
            pend_addr.push_back(bus.imem_req_addr);
            pend_due.push_back(cyc + 1 + int'($urandom_range(lat_max, lat_min)));
            acc_q.push_back(bus.imem_req_addr);
            n_req++;
            check("outstanding_max", 32'(pend_addr.size() <= MAX_OUT), 32'd1);
        end
        if (bus.imem_rsp_valid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (bus.redirect_valid) begin
            exp_restart(bus.redirect_pc & ~32'h3);
            acc_q.delete();
        end else if (bus.instr_valid && bus.instr_ready) begin
            e = exp_pop();
            check("instr_pc", bus.instr_pc, e);
            check("instr_data", bus.instr_data, e ^ KEY);
            n_pop++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Memory is reset together with the DUT, so its pending responses vanish.
    task automatic apply_reset();
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        redirect_pending   = 1'b0;
        prev_stalled       = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        acc_q.delete();
        exp_restart(RESET_PC);
        @(posedge clk);
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr_data", bus.instr_data, 32'd0);
        check("rst_instr_pc", bus.instr_pc, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(BOOT));
        rst_n = 1'b1;
        cyc = 0;
        first_valid_cyc = -1;
    endtask

    initial begin
        // Decode stalled: only two words may be requested, nothing lost.
        apply_reset();
        req_ready_pct = 100; instr_ready_pct = 0; lat_min = 0; lat_max = 0;
        p0 = n_req;
        repeat (10) tick();
        check("stall_req_count", 32'(n_req - p0), 32'd2);
        check("stall_addr0", acc_q[0], RESET_PC);
        check("stall_addr1", acc_q[1], RESET_PC + 32'd4);
        check("stall_req_valid", 32'(last_req_valid), 32'd0);
        check("stall_head_valid", 32'(bus.instr_valid), 32'd1);
        check("stall_head_pc", bus.instr_pc, RESET_PC);

        // Reset with a full buffer, then zero-wait streaming.
        apply_reset();
        instr_ready_pct = 100;
        p0 = n_pop;
        repeat (12) tick();
        check("first_valid_cycle", 32'(first_valid_cyc), 32'd3);
        check("stream_progress", 32'(n_pop - p0 >= 4), 32'd1);
        check("stream_addr0", acc_q[0], 32'h0);
        check("stream_addr1", acc_q[1], 32'h4);
        check("stream_addr2", acc_q[2], 32'h8);

        // Latency 3, redirect with two requests in flight.
        apply_reset();
        instr_ready_pct = 0; lat_min = 3; lat_max = 3;
        k = 0;
        while (pend_addr.size() < 2 && k < 20) begin
            tick();
            k++;
        end
        check("lat_outstanding", 32'(pend_addr.size()), 32'd2);
        redirect_target = 32'h100; redirect_pending = 1'b1;
        tick();
        check("lat_flush_state", 32'(dbg_state), 32'(FLUSH));
        check("lat_instr_valid", 32'(bus.instr_valid), 32'd0);
        instr_ready_pct = 100;
        p0 = n_pop;
        repeat (20) tick();
        check("lat_progress", 32'(n_pop - p0 >= 2), 32'd1);
        check("lat_first_addr", acc_q[0], 32'h100);
`ifdef FETCH_PERF_EN
        check("perf_dropped", perf_dropped, 32'd2);
`endif

        // Redirect in the cycle the first response arrives.
        apply_reset();
        instr_ready_pct = 0; lat_min = 0; lat_max = 0;
        tick();
        tick();
        redirect_target = 32'h200; redirect_pending = 1'b1;
        tick();
        check("same_req_forced_low", 32'(last_req_valid), 32'd0);
        check("same_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("same_state", 32'(dbg_state), 32'(RUN));
        instr_ready_pct = 100;
        p0 = n_pop;
        repeat (10) tick();
        check("same_progress", 32'(n_pop - p0 >= 2), 32'd1);
        check("same_first_addr", acc_q[0], 32'h200);

        // Misaligned redirect near the top of the address space wraps to zero.
        apply_reset();
        tick();
        tick();
        redirect_target = 32'hFFFF_FFFE; redirect_pending = 1'b1;
        tick();
        p0 = n_pop;
        repeat (12) tick();
        check("wrap_addr0", acc_q[0], 32'hFFFF_FFFC);
        check("wrap_addr1", acc_q[1], 32'h0000_0000);
        check("wrap_addr2", acc_q[2], 32'h0000_0004);
        check("wrap_progress", 32'(n_pop - p0 >= 3), 32'd1);

        // Random rounds, each starting with a mid-operation reset.
        for (int r = 0; r < 6; r++) begin
            apply_reset();
            req_ready_pct   = int'($urandom_range(100, 30));
            instr_ready_pct = int'($urandom_range(100, 20));
            lat_min = 0;
            lat_max = int'($urandom_range(4, 0));
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(99) < 3) begin
                    redirect_target  = $urandom;
                    redirect_pending = 1'b1;
                end
                tick();
            end
            req_ready_pct = 100; instr_ready_pct = 100;
            p0 = n_pop;
            repeat (40) tick();
            check("rand_drain_progress", 32'(n_pop - p0 > 0), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
